// File: rtl/icache_line_filler.sv
// Purpose: fills one 256-bit I-cache line from eight sequential 32-bit word reads.
// Latency: c_ready_o pulses 9 cycles after the strobe is sampled, plus one cycle per w_ack=0 wait.
// Backpressure: w_ack=0 stalls the fill in place; no new request is taken until c_strobe is seen low.
module icache_line_filler #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_SIZE  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c_strobe,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    output logic                  c_ready_o,
    output logic [LINE_SIZE-1:0]  c_dout_o,
    output logic                  w_req_o,
    output logic [ADDR_WIDTH-1:0] w_addr_o,
    input  logic                  w_ack,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [31:0]           fill_cnt_o
);

    localparam int BASE_W = ADDR_WIDTH - 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [BASE_W-1:0]     base_q, base_d;
    logic [2:0]            idx_q, idx_d;
    logic [LINE_SIZE-1:0]  line_q, line_d;
    logic                  req_q, req_d;
    logic                  rdy_q, rdy_d;
    logic [31:0]           cnt_q, cnt_d;

    // The low address bits select a byte inside the line and play no part in the fill.
    logic unused_addr_bits;
    assign unused_addr_bits = ^c_addr[4:0];

    // Word address is built from the latched base so mid-fill c_addr changes are invisible.
    assign w_addr_o   = (state_q == RD) ? {base_q, idx_q, 2'b00} : '0;
    assign w_req_o    = req_q;
    assign c_ready_o  = rdy_q;
    assign c_dout_o   = line_q;
    assign fill_cnt_o = cnt_q;

    // Next-state logic: request capture, word assembly, ready pulse and strobe drain.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        line_d  = line_q;
        req_d   = req_q;
        rdy_d   = rdy_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (c_strobe) begin
                    base_d  = c_addr[ADDR_WIDTH-1:5];
                    idx_d   = 3'd0;
                    req_d   = 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                if (w_ack) begin
                    // Word 0 lands in the most significant slot.
                    line_d[LINE_SIZE-1-DATA_WIDTH*int'(idx_q) -: DATA_WIDTH] = w_data;
                    if (idx_q == 3'd7) begin
                        req_d   = 1'b0;
                        rdy_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            DONE: begin
                rdy_d   = 1'b0;
                cnt_d   = cnt_q + 32'd1;
                state_d = DRAIN;
            end
            DRAIN: begin
                // The cache's registered strobe lingers one cycle past ready; wait it out.
                if (!c_strobe) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any fill in progress and discards the partial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            idx_q   <= 3'd0;
            line_q  <= '0;
            req_q   <= 1'b0;
            rdy_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
            req_q   <= req_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_icache_line_filler.sv
module tb_icache_line_filler;

    logic         clk = 1'b0;
    logic         rst;
    logic         c_strobe;
    logic [31:0]  c_addr;
    logic         c_ready_o;
    logic [255:0] c_dout_o;
    logic         w_req_o;
    logic [31:0]  w_addr_o;
    logic         w_ack;
    logic [31:0]  w_data;
    logic [31:0]  fill_cnt_o;

    icache_line_filler #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_SIZE(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .c_strobe   (c_strobe),
        .c_addr     (c_addr),
        .c_ready_o  (c_ready_o),
        .c_dout_o   (c_dout_o),
        .w_req_o    (w_req_o),
        .w_addr_o   (w_addr_o),
        .w_ack      (w_ack),
        .w_data     (w_data),
        .fill_cnt_o (fill_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          period;   // ack every Nth RD cycle; 0 means random acks
        int          hold;     // cycles strobe stays high after the ready cycle
        bit          midchg;   // change c_addr mid-fill
        int          exp_lat;  // expected strobe-sample-to-ready cycles; 0 = derive from waits
        logic [31:0] exp_last; // expected address of word 7
        logic [31:0] exp_cnt;  // expected fill count afterwards
        logic [31:0] dbase;    // word k data = dbase + k; 0 means random data
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] cnt_model;
    logic [31:0] exp_line [8];
    vec_t        tbl [6];
    logic [255:0] seq_line;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one complete fill and check it against the transaction-level expectation.
    task automatic do_fill(input vec_t v);
        int          k;
        int          waits;
        int          cyc;
        int          wc;
        bit          seen;
        bit          ack;
        logic [31:0] last;
        k = 0; waits = 0; cyc = 0; wc = 0; seen = 0; last = 32'h0;
        @(negedge clk);
        c_strobe = 1'b1;
        c_addr   = v.addr;
        w_ack    = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (c_ready_o) begin
                seen = 1'b1;
            end else begin
                chk("w_req_mid_fill", {255'd0, w_req_o}, 256'd1);
                chk("w_addr", {224'd0, w_addr_o}, {224'd0, v.addr[31:5], k[2:0], 2'b00});
                if (k == 7) last = w_addr_o;
                if (v.midchg && k == 2) c_addr = 32'hDEAD_0000;
                if (v.period > 0) begin
                    wc++;
                    ack = (wc == v.period);
                    if (ack) wc = 0;
                end else begin
                    ack = ($urandom_range(0, 2) != 0);
                end
                w_ack  = ack;
                w_data = (v.dbase != 0) ? v.dbase + 32'(k) : $urandom;
                if (ack) begin
                    exp_line[k[2:0]] = w_data;
                    k++;
                end else begin
                    waits++;
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: no c_ready_o within %0d cycles, acks=%0d", cyc, k);
        end else begin
            chk("latency_vs_waits", 256'(cyc), 256'(9 + waits));
            if (v.exp_lat != 0) chk("latency", 256'(cyc), 256'(v.exp_lat));
            chk("acks_taken", 256'(k), 256'd8);
            chk("line", c_dout_o, {exp_line[0], exp_line[1], exp_line[2], exp_line[3],
                                   exp_line[4], exp_line[5], exp_line[6], exp_line[7]});
            chk("last_w_addr", {224'd0, last}, {224'd0, v.exp_last});
            chk("w_req_in_done", {255'd0, w_req_o}, 256'd0);
            cnt_model = cnt_model + 32'd1;
        end
        // Acks outside RD must be ignored.
        w_ack  = 1'b1;
        w_data = $urandom;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("ready_pulse_hold", {255'd0, c_ready_o}, 256'd0);
            chk("no_refill_overlap", {255'd0, w_req_o}, 256'd0);
        end
        c_strobe = 1'b0;
        c_addr   = $urandom;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("ready_pulse_after", {255'd0, c_ready_o}, 256'd0);
            chk("w_req_idle", {255'd0, w_req_o}, 256'd0);
            chk("w_addr_idle", {224'd0, w_addr_o}, 256'd0);
            if (j == 0) chk("fill_cnt", {224'd0, fill_cnt_o}, {224'd0, cnt_model});
        end
        w_ack = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'h0000_1234, 1, 0, 1'b0,  9, 32'h0000_123C, 32'd1, 32'h0000_00A0};
        tbl[1] = '{32'h0000_1234, 3, 1, 1'b0, 25, 32'h0000_123C, 32'd2, 32'h0000_00A0};
        tbl[2] = '{32'h0000_2000, 1, 0, 1'b0,  9, 32'h0000_201C, 32'd3, 32'h0};
        tbl[3] = '{32'h0000_5640, 2, 0, 1'b1, 17, 32'h0000_565C, 32'd4, 32'h0};
        tbl[4] = '{32'hFFFF_FFE0, 1, 0, 1'b0,  9, 32'hFFFF_FFFC, 32'd5, 32'h0};
        tbl[5] = '{32'hFFFF_FFE0, 2, 0, 1'b0, 17, 32'hFFFF_FFFC, 32'd0, 32'h0};
        seq_line = 256'h000000A0_000000A1_000000A2_000000A3_000000A4_000000A5_000000A6_000000A7;

        rst = 1'b1; c_strobe = 1'b0; c_addr = 32'h0; w_ack = 1'b0; w_data = 32'h0;
        cnt_model = 32'd0;
        #3;
        chk("rst_w_req", {255'd0, w_req_o}, 256'd0);
        chk("rst_ready", {255'd0, c_ready_o}, 256'd0);
        chk("rst_dout", c_dout_o, 256'd0);
        chk("rst_cnt", {224'd0, fill_cnt_o}, 256'd0);
        chk("rst_w_addr", {224'd0, w_addr_o}, 256'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_fill(tbl[i]);
            chk("tbl_cnt", {224'd0, fill_cnt_o}, {224'd0, tbl[i].exp_cnt});
            if (tbl[i].dbase != 0) chk("tbl_seq_line", c_dout_o, seq_line);
        end

        // Asynchronous reset after the fourth ack of a fill.
        @(negedge clk);
        c_strobe = 1'b1; c_addr = 32'h0000_3300;
        @(negedge clk);
        w_ack = 1'b1; w_data = 32'h1111_1111;
        repeat (4) @(negedge clk);
        w_ack = 1'b0;
        chk("pre_rst_w_req", {255'd0, w_req_o}, 256'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_w_req", {255'd0, w_req_o}, 256'd0);
        chk("arst_ready", {255'd0, c_ready_o}, 256'd0);
        chk("arst_cnt", {224'd0, fill_cnt_o}, 256'd0);
        chk("arst_dout", c_dout_o, 256'd0);
        chk("arst_w_addr", {224'd0, w_addr_o}, 256'd0);
        c_strobe = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cnt_model = 32'd0;
        w_ack = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_no_ready", {255'd0, c_ready_o}, 256'd0);
            chk("post_rst_no_req", {255'd0, w_req_o}, 256'd0);
        end
        w_ack = 1'b0;

        // Counter wrap: preload all-ones, one more fill wraps to zero.
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cnt_q;
        cnt_model = 32'hFFFF_FFFF;
        do_fill(tbl[5]);
        chk("cnt_wrap", {224'd0, fill_cnt_o}, {224'd0, tbl[5].exp_cnt});

        // Randomized fills against the transaction-level model.
        for (int r = 0; r < 16; r++) begin
            vec_t rv;
            rv.addr     = $urandom;
            rv.period   = 0;
            rv.hold     = $urandom_range(0, 2);
            rv.midchg   = 1'($urandom_range(0, 1));
            rv.exp_lat  = 0;
            rv.exp_last = {rv.addr[31:5], 5'b11100};
            rv.exp_cnt  = 32'd0;
            rv.dbase    = 32'h0;
            do_fill(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
